// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Contents: the fetch state enum, the reset PC constant and the FIFO write-line struct.
// Imported by inst_fetch_ctrl and fetch_pair_pack.
package inst_fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    // One FIFO write line. Every field is zero whenever en is low.
    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        logic [31:0] data;
        logic        tlb_refill;
        logic        tlb_invalid;
    } fifo_entry_t;

endpackage

// File: rtl/fetch_pair_pack.sv
// Splits one I-cache response into the two FIFO write lines (purely combinational).
// Ports: wr_vld qualifies the write; req_pc, rdata1/2 and the TLB flags come from the response;
//        line1/line2 are the packed slot 1 / slot 2 write lines.
module fetch_pair_pack
    import inst_fetch_ctrl_pkg::*;
(
    input  logic        wr_vld,
    input  logic [31:0] req_pc,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic        tlb_refill,
    input  logic        tlb_invalid,
    output fifo_entry_t line1,
    output fifo_entry_t line2
);

    logic tlb_fault;
    logic odd_half;

    assign tlb_fault = tlb_refill | tlb_invalid;
    // The pair is fetched 8-aligned; an odd-word PC only wants the upper instruction.
    assign odd_half  = req_pc[2];

    always_comb begin
        line1 = '0;
        line2 = '0;
        if (wr_vld) begin
            line1.en          = 1'b1;
            line1.addr        = req_pc;
            line1.data        = odd_half ? rdata2 : rdata1;
            line1.tlb_refill  = tlb_refill;
            line1.tlb_invalid = tlb_invalid;
            // A faulting fetch delivers only the faulting slot; the second slot is never written.
            if (!odd_half && !tlb_fault) begin
                line2.en   = 1'b1;
                line2.addr = req_pc + 32'd4;
                line2.data = rdata2;
            end
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Dual-issue fetch controller: owns the fetch PC, issues one I-cache pair request at a time
// and turns each response into a FIFO write pair; redirects reset the FIFO and discard in-flight data.
// Ports: clk/rst (sync, active-high), redirect/redirect_pc, fifo_full, I-cache req/resp, fifo_rst, write_* slots.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        fifo_full,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata1,
    input  logic [31:0] inst_rdata2,
    input  logic        inst_tlb_refill,
    input  logic        inst_tlb_invalid,
    output logic        fifo_rst,
    output logic        write_en1,
    output logic        write_en2,
    output logic [31:0] write_address1,
    output logic [31:0] write_address2,
    output logic [31:0] write_data1,
    output logic [31:0] write_data2,
    output logic        write_tlb_refill1,
    output logic        write_tlb_refill2,
    output logic        write_tlb_invalid1,
    output logic        write_tlb_invalid2
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         discard_q, discard_d;

    logic         wr_vld;
    logic         tlb_fault;
    fifo_entry_t  line1, line2;

    assign tlb_fault = inst_tlb_refill | inst_tlb_invalid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            req_pc_q  <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        discard_d = discard_q;

        if (redirect) begin
            // Redirect overrides everything; only an accepted-but-unreturned request
            // needs to be tracked so its response can be swallowed.
            pc_d = redirect_pc;
            case (state_q)
                ST_REQ: begin
                    if (inst_addr_ok) begin
                        state_d   = ST_WAIT;
                        discard_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (inst_data_ok) begin
                        state_d   = ST_IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d   = ST_WAIT;
                        discard_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Room is checked only here: with one request outstanding the
                    // response always fits.
                    if (!fifo_full) state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (inst_addr_ok) begin
                        req_pc_d = pc_q;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (inst_data_ok) begin
                        if (discard_q) begin
                            // Stale response from before a redirect; pc already holds the target.
                            discard_d = 1'b0;
                            state_d   = ST_IDLE;
                        end else if (tlb_fault) begin
                            state_d = ST_HALT;
                        end else begin
                            // Odd-word start consumed one instruction; re-align to the next pair.
                            pc_d    = req_pc_q + (req_pc_q[2] ? 32'd4 : 32'd8);
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_HALT;
            endcase
        end
    end

    // Outputs
    always_comb begin
        inst_req  = (state_q == ST_REQ);
        inst_addr = {pc_q[31:3], 3'b000};
        fifo_rst  = redirect;
        wr_vld    = (state_q == ST_WAIT) && inst_data_ok && !discard_q && !redirect;
    end

    fetch_pair_pack u_pack (
        .wr_vld      (wr_vld),
        .req_pc      (req_pc_q),
        .rdata1      (inst_rdata1),
        .rdata2      (inst_rdata2),
        .tlb_refill  (inst_tlb_refill),
        .tlb_invalid (inst_tlb_invalid),
        .line1       (line1),
        .line2       (line2)
    );

    assign write_en1          = line1.en;
    assign write_address1     = line1.addr;
    assign write_data1        = line1.data;
    assign write_tlb_refill1  = line1.tlb_refill;
    assign write_tlb_invalid1 = line1.tlb_invalid;
    assign write_en2          = line2.en;
    assign write_address2     = line2.addr;
    assign write_data2        = line2.data;
    assign write_tlb_refill2  = line2.tlb_refill;
    assign write_tlb_invalid2 = line2.tlb_invalid;

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Dual-issue instruction fetch controller that sits directly upstream of the instruction FIFO. It owns the fetch PC and issues one sram-like I-cache request at a time for an aligned 8-byte instruction pair. Each response is converted into the FIFO write pair: write enables, addresses, data and TLB flags. It also handles redirects from the back end by resetting the FIFO and discarding any in-flight response.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, fetch PC after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- redirect  in  1  back end requests a PC change (branch, exception or eret).
- redirect_pc  in  32  target PC for the redirect.
- fifo_full  in  1  FIFO cannot accept two entries.
- inst_req  out  1  I-cache request valid.
- inst_addr  out  32  request address, {pc[31:3], 3'b000}.
- inst_addr_ok  in  1  I-cache accepted the request this cycle.
- inst_data_ok  in  1  response valid this cycle.
- inst_rdata1  in  32  instruction at offset 0 of the pair.
- inst_rdata2  in  32  instruction at offset 4 of the pair.
- inst_tlb_refill  in  1  TLB refill on the request address.
- inst_tlb_invalid  in  1  TLB invalid on the request address.
- fifo_rst  out  1  FIFO pointer reset pulse.
- write_en1  out  1  FIFO write, slot 1.
- write_en2  out  1  FIFO write, slot 2.
- write_address1  out  32  PC for slot 1.
- write_address2  out  32  PC for slot 2.
- write_data1  out  32  instruction for slot 1.
- write_data2  out  32  instruction for slot 2.
- write_tlb_refill1  out  1  TLB refill flag, slot 1.
- write_tlb_refill2  out  1  TLB refill flag, slot 2.
- write_tlb_invalid1  out  1  TLB invalid flag, slot 1.
- write_tlb_invalid2  out  1  TLB invalid flag, slot 2.

## Operation
State machine: IDLE, REQ, WAIT, HALT. A 1-bit `discard` flag and a registered `req_pc` accompany it.
- IDLE: if !fifo_full and !redirect, go to REQ. inst_req is not asserted in IDLE.
- REQ: inst_req=1 with inst_addr derived from pc. On inst_addr_ok, latch req_pc=pc and go to WAIT.
- WAIT: on inst_data_ok, go to IDLE. If not discarding, write the pair to the FIFO in the same cycle:
  - If req_pc[2]==0: write_en1=write_en2=1, addresses req_pc and req_pc+4, data rdata1 and rdata2.
  - If req_pc[2]==1: only slot 1 is written, with address req_pc and data rdata2.
- Next-pc update on data_ok: pc = req_pc+8 if req_pc[2]==0, else req_pc+4. This keeps pc 8-aligned after the first pair.
- TLB flag on response (refill or invalid):
  - Write slot 1 only, carrying the flags. write_en2=0.
  - Go to HALT and do not advance pc.
  - HALT leaves only on redirect.
- Redirect takes priority over all other events:
  - fifo_rst=1 that cycle; pc<=redirect_pc next cycle.
  - All write_en outputs are forced to 0 that cycle.
  - In REQ with inst_addr_ok=0: drop the request and go to IDLE.
  - In REQ with inst_addr_ok=1, or in WAIT with inst_data_ok=0: set discard and go to WAIT. The late response is consumed without a write; discard clears and the state goes to IDLE on that data_ok.
  - In WAIT with inst_data_ok=1: drop the data and go to IDLE.
  - In HALT or IDLE: go to IDLE.
- fifo_full is sampled only in IDLE. With at most one request outstanding, the FIFO always has room for the response.
- Arithmetic is 32-bit with wrap-around; no address-error detection (the back end does it).

## Timing
- Reset values: pc=RESET_PC, state IDLE, discard=0. inst_req=0, fifo_rst=0, all write_en=0, all write_* data/address/flag outputs 0.
- Minimum turnaround is three cycles: IDLE, then REQ (accepted the same cycle if addr_ok), then WAIT with data_ok. Request-to-FIFO-write latency is 1 cycle after addr_ok when data_ok returns next cycle.
- FIFO write outputs are combinational from the response and are valid only in the data_ok cycle.
- fifo_rst is combinational from redirect and is 1 cycle wide per redirect cycle.
- Back-to-back redirects: the last one wins. discard stays set until one response has returned.

## Structure
- Shared package: the fetch state enum (IDLE/REQ/WAIT/HALT) and the RESET_PC constant, plus the existing fifo_entry typedef used to pack write lines.
- One sub-module is natural: `fetch_pair_pack`, the combinational split of a response into the two FIFO write lines from req_pc[2] and the TLB flags.

## Test plan
- Reset then addr_ok and data_ok each 1 cycle: first write at addresses BFC00000 and BFC00004, both enables high. The next request is to BFC00008.
- Redirect to 80000004: fifo_rst pulses. The following response writes only slot 1 at 80000004 with rdata2, and the next request is to 80000008.
- Redirect in WAIT, data_ok 3 cycles later: no FIFO write for that response. The next request is to redirect_pc.
- fifo_full held high in IDLE for 5 cycles: inst_req stays 0. inst_req asserts the cycle after full drops.
- Response with tlb_refill=1: write_en1=1 with refill1=1, write_en2=0. No further inst_req until a redirect.
- Redirect in the same cycle as data_ok: write_en1 and write_en2 are 0 and fifo_rst=1. The next request is to redirect_pc.
